// File: rtl/processor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : processor_pkg
// Description : Shared definitions for the asm18 operand stage: opcode
//               encodings, condition codes, wait FSM states and the imm8
//               sign-extension helper.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package processor_pkg;

    // Widest address the sign-extension helper serves; callers truncate.
    localparam int EXT_W = 64;

    // Opcode field code_word[17:14]
    localparam logic [3:0] OP_REG_ADD_IMM8 = 4'd0;
    localparam logic [3:0] OP_REG_ADD      = 4'd1;
    localparam logic [3:0] OP_REG_SUB      = 4'd2;
    localparam logic [3:0] OP_REG_AND      = 4'd3;
    localparam logic [3:0] OP_REG_OR       = 4'd4;
    localparam logic [3:0] OP_REG_XOR      = 4'd5;
    localparam logic [3:0] OP_LOAD         = 4'd6;
    localparam logic [3:0] OP_STORE        = 4'd7;
    localparam logic [3:0] OP_IF           = 4'd8;
    localparam logic [3:0] OP_CALL_IMM14   = 4'd9;
    localparam logic [3:0] OP_RETURN       = 4'd10;
    localparam logic [3:0] OP_WAIT         = 4'd11;

    // Stack pointer register index, read as the call target memory address
    localparam logic [2:0] SP_REG = 3'd7;

    // Condition codes carried in code_word[10:8] for OP_IF
    localparam logic [2:0] IF_EQZ    = 3'd0;
    localparam logic [2:0] IF_NEZ    = 3'd1;
    localparam logic [2:0] IF_LTZ    = 3'd2;
    localparam logic [2:0] IF_GEZ    = 3'd3;
    localparam logic [2:0] IF_GTZ    = 3'd4;
    localparam logic [2:0] IF_LEZ    = 3'd5;
    localparam logic [2:0] IF_ALWAYS = 3'd6;
    localparam logic [2:0] IF_NEVER  = 3'd7;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_COUNT = 2'd1,
        WAIT_EVENT = 2'd2
    } wait_state_t;

    function automatic logic [EXT_W-1:0] sign_extend8(input logic [7:0] value);
        return {{(EXT_W-8){value[7]}}, value};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_control.sv
`default_nettype none
// ============================================================================
// Module      : if_control
// Description : Evaluates the OP_IF condition on a two's-complement operand.
// Ports       : data (operand), if_op (condition code), condition_true (result)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module if_control
    import processor_pkg::*;
#(
    parameter int WORD_SIZE = 18
) (
    input  logic [WORD_SIZE-1:0] data,
    input  logic [2:0]           if_op,
    output logic                 condition_true
);

    logic is_zero;
    logic is_neg;

    assign is_zero = (data == '0);
    assign is_neg  = data[WORD_SIZE-1];

    always_comb begin
        condition_true = 1'b0;
        case (if_op)
            IF_EQZ:    condition_true = is_zero;
            IF_NEZ:    condition_true = !is_zero;
            IF_LTZ:    condition_true = is_neg;
            IF_GEZ:    condition_true = !is_neg;
            IF_GTZ:    condition_true = !is_neg && !is_zero;
            IF_LEZ:    condition_true = is_neg || is_zero;
            IF_ALWAYS: condition_true = 1'b1;
            default:   condition_true = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/processor_operand_stage_operand_forward.sv
`default_nettype none
// ============================================================================
// Module      : operand_forward
// Description : Priority mux selecting a register operand from the writeback
//               forwarding ports; lowest matching port index wins, otherwise
//               the register file data passes through.
// Ports       : read_addr, rf_data, fwd_write_enable/addr/data (packed by
//               port), operand (selected value)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module operand_forward #(
    parameter int WORD_SIZE = 18,
    parameter int FWD_PORTS = 2
) (
    input  logic [2:0]                     read_addr,
    input  logic [WORD_SIZE-1:0]           rf_data,
    input  logic [FWD_PORTS-1:0]           fwd_write_enable,
    input  logic [3*FWD_PORTS-1:0]         fwd_write_addr,
    input  logic [WORD_SIZE*FWD_PORTS-1:0] fwd_write_data,
    output logic [WORD_SIZE-1:0]           operand
);

    // Walk from the oldest port to the youngest so the youngest match is the
    // last assignment and therefore wins.
    always_comb begin
        operand = rf_data;
        for (int k = FWD_PORTS - 1; k >= 0; k--) begin
            if (fwd_write_enable[k] && (fwd_write_addr[3*k +: 3] == read_addr)) begin
                operand = fwd_write_data[WORD_SIZE*k +: WORD_SIZE];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/processor_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : processor_operand_stage
// Description : asm18 stage-2 operand fetch. Reads two register operands with
//               writeback forwarding, issues load/store/call memory accesses,
//               resolves if/call/return and runs a timed or event-driven wait.
// Ports       : clock/reset_n; upstream slot (no_operation, ip, ip_plus_one,
//               code_word); hold_in, wake_event, wait_abort; memory port
//               (combinational); register file read port; forwarding ports;
//               registered downstream outputs; ip_to_call/call_performed
//               redirect; waiting_global.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module processor_operand_stage
    import processor_pkg::*;
#(
    parameter int ADDR_SIZE     = 18,
    parameter int WORD_SIZE     = 18,
    parameter int FWD_PORTS     = 2,
    parameter int WAIT_CNT_BITS = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           no_operation,
    input  logic [ADDR_SIZE-1:0]           ip,
    input  logic [ADDR_SIZE-1:0]           ip_plus_one,
    input  logic [WORD_SIZE-1:0]           code_word,
    input  logic                           hold_in,
    input  logic                           wake_event,
    input  logic                           wait_abort,
    output logic [ADDR_SIZE-1:0]           memory_addr,
    output logic                           memory_write_enable,
    output logic [WORD_SIZE-1:0]           memory_in,
    output logic [2:0]                     reg_read_addr0,
    output logic [2:0]                     reg_read_addr1,
    input  logic [WORD_SIZE-1:0]           reg_read_data0,
    input  logic [WORD_SIZE-1:0]           reg_read_data1,
    input  logic [FWD_PORTS-1:0]           fwd_write_enable,
    input  logic [3*FWD_PORTS-1:0]         fwd_write_addr,
    input  logic [WORD_SIZE*FWD_PORTS-1:0] fwd_write_data,
    output logic                           no_operation_out,
    output logic [WORD_SIZE-1:0]           alu_data0_out,
    output logic [WORD_SIZE-1:0]           alu_data1_out,
    output logic [WORD_SIZE-1:0]           code_word_out,
    output logic [ADDR_SIZE-1:0]           data1_plus_imm8_out,
    output logic                           return_performed,
    output logic [ADDR_SIZE-1:0]           ip_to_call,
    output logic                           call_performed,
    output logic                           waiting_global
);

    // Instruction fields
    logic [3:0]  op;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [7:0]  imm8;
    logic [13:0] imm14;

    assign op    = code_word[17:14];
    assign rx    = code_word[13:11];
    assign ry    = code_word[10:8];
    assign imm8  = code_word[7:0];
    assign imm14 = code_word[13:0];

    wait_state_t              state_q, state_d;
    logic [WAIT_CNT_BITS-1:0] counter_q, counter_d;

    logic                 active;
    logic                 wait_accept;
    logic [WORD_SIZE-1:0] data0;
    logic [WORD_SIZE-1:0] data1;
    logic [ADDR_SIZE-1:0] imm8_sext;
    logic [ADDR_SIZE-1:0] data1_plus_imm8;
    logic [ADDR_SIZE-1:0] ip_plus_imm8;
    logic                 if_ok;

    assign active      = !no_operation && (state_q == RUN) && !hold_in;
    assign wait_accept = active && (op == OP_WAIT);

    // Calls push the return address through the stack pointer.
    assign reg_read_addr0 = rx;
    assign reg_read_addr1 = (op == OP_CALL_IMM14) ? SP_REG : ry;

    operand_forward #(
        .WORD_SIZE (WORD_SIZE),
        .FWD_PORTS (FWD_PORTS)
    ) u_forward0 (
        .read_addr        (reg_read_addr0),
        .rf_data          (reg_read_data0),
        .fwd_write_enable (fwd_write_enable),
        .fwd_write_addr   (fwd_write_addr),
        .fwd_write_data   (fwd_write_data),
        .operand          (data0)
    );

    operand_forward #(
        .WORD_SIZE (WORD_SIZE),
        .FWD_PORTS (FWD_PORTS)
    ) u_forward1 (
        .read_addr        (reg_read_addr1),
        .rf_data          (reg_read_data1),
        .fwd_write_enable (fwd_write_enable),
        .fwd_write_addr   (fwd_write_addr),
        .fwd_write_data   (fwd_write_data),
        .operand          (data1)
    );

    if_control #(
        .WORD_SIZE (WORD_SIZE)
    ) u_if_control (
        .data           (data0),
        .if_op          (ry),
        .condition_true (if_ok)
    );

    assign imm8_sext       = ADDR_SIZE'(sign_extend8(imm8));
    assign data1_plus_imm8 = data1[ADDR_SIZE-1:0] + imm8_sext;
    assign ip_plus_imm8    = ip + imm8_sext;

    // Memory port and redirect. Address and data follow the opcode even in
    // idle slots; only the strobes are gated by active.
    always_comb begin
        memory_addr         = data1_plus_imm8;
        memory_in           = data0;
        memory_write_enable = 1'b0;
        call_performed      = 1'b0;
        ip_to_call          = ip_plus_imm8;
        if (op == OP_CALL_IMM14) begin
            memory_addr = data1[ADDR_SIZE-1:0];
            memory_in   = WORD_SIZE'(ip_plus_one);
            ip_to_call  = ADDR_SIZE'(imm14);
        end
        if (active) begin
            case (op)
                OP_STORE:      memory_write_enable = 1'b1;
                OP_CALL_IMM14: begin
                    memory_write_enable = 1'b1;
                    call_performed      = 1'b1;
                end
                OP_IF:         call_performed = if_ok;
                default:       ;
            endcase
        end
    end

    // Wait FSM next state. The counter runs even while hold_in is high so a
    // timed wait always lasts exactly imm8 cycles.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        case (state_q)
            RUN: begin
                if (wait_accept) begin
                    if (imm8 != 8'd0) begin
                        state_d   = WAIT_COUNT;
                        counter_d = WAIT_CNT_BITS'(imm8);
                    end else begin
                        state_d = WAIT_EVENT;
                    end
                end
            end
            WAIT_COUNT: begin
                if (wait_abort || (counter_q == WAIT_CNT_BITS'(1))) begin
                    state_d   = RUN;
                    counter_d = '0;
                end else begin
                    counter_d = counter_q - WAIT_CNT_BITS'(1);
                end
            end
            WAIT_EVENT: begin
                if (wait_abort || wake_event) begin
                    state_d   = RUN;
                    counter_d = '0;
                end
            end
            default: begin
                state_d   = RUN;
                counter_d = '0;
            end
        endcase
    end

    // Downstream register next values; the bubble flag also covers the wait
    // instruction itself and every cycle spent waiting.
    logic no_operation_out_d;
    logic return_performed_d;

    assign no_operation_out_d = no_operation || (state_q != RUN) || wait_accept;
    assign return_performed_d = active && (op == OP_RETURN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q             <= RUN;
            counter_q           <= '0;
            no_operation_out    <= 1'b1;
            return_performed    <= 1'b0;
            alu_data0_out       <= '0;
            alu_data1_out       <= '0;
            code_word_out       <= '0;
            data1_plus_imm8_out <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            if (!hold_in) begin
                no_operation_out    <= no_operation_out_d;
                return_performed    <= return_performed_d;
                alu_data0_out       <= data0;
                alu_data1_out       <= data1;
                code_word_out       <= code_word;
                data1_plus_imm8_out <= data1_plus_imm8;
            end
        end
    end

    assign waiting_global = (state_q != RUN);

endmodule
`default_nettype wire

// File: tb/tb_processor_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_processor_operand_stage
// Description : Self-checking bench for processor_operand_stage with a
//               behavioural register-file/forwarding/memory reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_processor_operand_stage;
    import processor_pkg::*;

    localparam int AW   = 18;
    localparam int WW   = 18;
    localparam int NP   = 2;
    localparam int MASK = 32'h3FFFF;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            no_operation;
    logic [AW-1:0]   ip;
    logic [AW-1:0]   ip_plus_one;
    logic [WW-1:0]   code_word;
    logic            hold_in;
    logic            wake_event;
    logic            wait_abort;
    logic [AW-1:0]   memory_addr;
    logic            memory_write_enable;
    logic [WW-1:0]   memory_in;
    logic [2:0]      reg_read_addr0;
    logic [2:0]      reg_read_addr1;
    logic [WW-1:0]   reg_read_data0;
    logic [WW-1:0]   reg_read_data1;
    logic [NP-1:0]   fwd_write_enable;
    logic [3*NP-1:0] fwd_write_addr;
    logic [WW*NP-1:0] fwd_write_data;
    logic            no_operation_out;
    logic [WW-1:0]   alu_data0_out;
    logic [WW-1:0]   alu_data1_out;
    logic [WW-1:0]   code_word_out;
    logic [AW-1:0]   data1_plus_imm8_out;
    logic            return_performed;
    logic [AW-1:0]   ip_to_call;
    logic            call_performed;
    logic            waiting_global;

    // Register file and forwarding port model
    logic [WW-1:0] rf [8];
    logic [NP-1:0] fen;
    logic [2:0]    fad [NP];
    logic [WW-1:0] fdat [NP];

    assign reg_read_data0   = rf[reg_read_addr0];
    assign reg_read_data1   = rf[reg_read_addr1];
    assign fwd_write_enable = fen;
    assign fwd_write_addr   = {fad[1], fad[0]};
    assign fwd_write_data   = {fdat[1], fdat[0]};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    processor_operand_stage #(
        .ADDR_SIZE(AW), .WORD_SIZE(WW), .FWD_PORTS(NP), .WAIT_CNT_BITS(8)
    ) dut (
        .clock(clock), .reset_n(reset_n), .no_operation(no_operation),
        .ip(ip), .ip_plus_one(ip_plus_one), .code_word(code_word),
        .hold_in(hold_in), .wake_event(wake_event), .wait_abort(wait_abort),
        .memory_addr(memory_addr), .memory_write_enable(memory_write_enable),
        .memory_in(memory_in), .reg_read_addr0(reg_read_addr0),
        .reg_read_addr1(reg_read_addr1), .reg_read_data0(reg_read_data0),
        .reg_read_data1(reg_read_data1), .fwd_write_enable(fwd_write_enable),
        .fwd_write_addr(fwd_write_addr), .fwd_write_data(fwd_write_data),
        .no_operation_out(no_operation_out), .alu_data0_out(alu_data0_out),
        .alu_data1_out(alu_data1_out), .code_word_out(code_word_out),
        .data1_plus_imm8_out(data1_plus_imm8_out),
        .return_performed(return_performed), .ip_to_call(ip_to_call),
        .call_performed(call_performed), .waiting_global(waiting_global)
    );

    // ---------------- reference model helpers ----------------
    function automatic int fwd_val(int a);
        for (int k = 0; k < NP; k++)
            if (fen[k] && int'(fad[k]) == a) return int'(fdat[k]);
        return int'(rf[a]);
    endfunction

    function automatic int sx8(int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic bit if_model(int d, int c);
        int s;
        s = (d >= 131072) ? d - 262144 : d;
        case (c)
            0: return s == 0;
            1: return s != 0;
            2: return s < 0;
            3: return s >= 0;
            4: return s > 0;
            5: return s <= 0;
            6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [17:0] mk(logic [3:0] op, int rx, int ry, int imm);
        logic [17:0] w;
        w = {op, 3'(rx), 3'(ry), 8'(imm)};
        return w;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; no_operation = 1'b1; hold_in = 1'b0; wake_event = 1'b0;
        wait_abort = 1'b0; ip = '0; ip_plus_one = '0; code_word = '0; fen = '0;
        for (int i = 0; i < NP; i++) begin fad[i] = '0; fdat[i] = '0; end
        for (int i = 0; i < 8; i++) rf[i] = '0;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (no_operation_out !== 1'b1) begin n_err++; $display("FAIL reset_nop: got %0b want 1", no_operation_out); end
        n_cmp++; if (return_performed !== 1'b0) begin n_err++; $display("FAIL reset_ret: got %0b want 0", return_performed); end
        n_cmp++; if (alu_data0_out !== '0 || alu_data1_out !== '0) begin n_err++; $display("FAIL reset_alu: got %0h/%0h want 0/0", alu_data0_out, alu_data1_out); end
        n_cmp++; if (code_word_out !== '0 || data1_plus_imm8_out !== '0) begin n_err++; $display("FAIL reset_cw: got %0h/%0h want 0/0", code_word_out, data1_plus_imm8_out); end
        n_cmp++; if (waiting_global !== 1'b0) begin n_err++; $display("FAIL reset_wait: got %0b want 0", waiting_global); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_forwarding();
        rf[3] = 18'h00333; rf[1] = 18'h00001;
        fen = 2'b11; fad[0] = 3'd3; fad[1] = 3'd3; fdat[0] = 18'h00011; fdat[1] = 18'h00022;
        no_operation = 1'b0; code_word = mk(OP_REG_ADD, 3, 1, 0);
        tick();
        n_cmp++; if (alu_data0_out !== 18'h00011) begin n_err++; $display("FAIL fwd_both: got %0h want 11", alu_data0_out); end
        fen = 2'b10;
        tick();
        n_cmp++; if (alu_data0_out !== 18'h00022) begin n_err++; $display("FAIL fwd_port1: got %0h want 22", alu_data0_out); end
        fen = 2'b00;
        tick();
        n_cmp++; if (alu_data0_out !== 18'h00333) begin n_err++; $display("FAIL fwd_none: got %0h want 333", alu_data0_out); end
    endtask

    task automatic test_random_ops();
        for (int it = 0; it < 60; it++) begin
            int op, rx, ry, imm, a1, d0, d1, s;
            bit nop, act, e_we, e_cp;
            logic [17:0] e_d1pi, e_addr, e_in, e_ip, e_cw;
            op = $urandom_range(0, 15);
            if (op == int'(OP_WAIT)) op = int'(OP_STORE);
            rx = $urandom_range(0, 7); ry = $urandom_range(0, 7); imm = $urandom_range(0, 255);
            nop = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < 8; i++) rf[i] = 18'($urandom);
            fen = 2'($urandom);
            for (int k = 0; k < NP; k++) begin fad[k] = 3'($urandom); fdat[k] = 18'($urandom); end
            ip = 18'($urandom); ip_plus_one = 18'($urandom);
            e_cw = mk(4'(op), rx, ry, imm);
            code_word = e_cw; no_operation = nop;
            a1 = (op == int'(OP_CALL_IMM14)) ? 7 : ry;
            d0 = fwd_val(rx); d1 = fwd_val(a1); s = sx8(imm);
            e_d1pi = 18'((d1 + s) & MASK);
            act = !nop;
            e_we = act && (op == int'(OP_STORE) || op == int'(OP_CALL_IMM14));
            e_cp = act && (op == int'(OP_CALL_IMM14) || (op == int'(OP_IF) && if_model(d0, ry)));
            e_addr = (op == int'(OP_CALL_IMM14)) ? 18'(d1) : e_d1pi;
            e_in   = (op == int'(OP_CALL_IMM14)) ? ip_plus_one : 18'(d0);
            e_ip   = (op == int'(OP_IF)) ? 18'((int'(ip) + s) & MASK) : 18'(e_cw[13:0]);
            #1;
            n_cmp++; if (reg_read_addr0 !== 3'(rx) || reg_read_addr1 !== 3'(a1)) begin n_err++; $display("FAIL rand_raddr it%0d: got %0d/%0d want %0d/%0d", it, reg_read_addr0, reg_read_addr1, rx, a1); end
            n_cmp++; if (memory_write_enable !== e_we) begin n_err++; $display("FAIL rand_we it%0d op%0d: got %0b want %0b", it, op, memory_write_enable, e_we); end
            n_cmp++; if (call_performed !== e_cp) begin n_err++; $display("FAIL rand_call it%0d op%0d: got %0b want %0b", it, op, call_performed, e_cp); end
            if (op == int'(OP_LOAD) || op == int'(OP_STORE) || op == int'(OP_CALL_IMM14)) begin
                n_cmp++; if (memory_addr !== e_addr) begin n_err++; $display("FAIL rand_addr it%0d op%0d: got %0h want %0h", it, op, memory_addr, e_addr); end
            end
            if (e_we) begin
                n_cmp++; if (memory_in !== e_in) begin n_err++; $display("FAIL rand_min it%0d op%0d: got %0h want %0h", it, op, memory_in, e_in); end
            end
            if (op == int'(OP_IF) || op == int'(OP_CALL_IMM14)) begin
                n_cmp++; if (ip_to_call !== e_ip) begin n_err++; $display("FAIL rand_target it%0d op%0d: got %0h want %0h", it, op, ip_to_call, e_ip); end
            end
            tick();
            n_cmp++; if (alu_data0_out !== 18'(d0) || alu_data1_out !== 18'(d1)) begin n_err++; $display("FAIL rand_alu it%0d: got %0h/%0h want %0h/%0h", it, alu_data0_out, alu_data1_out, d0, d1); end
            n_cmp++; if (code_word_out !== e_cw || data1_plus_imm8_out !== e_d1pi) begin n_err++; $display("FAIL rand_cw it%0d: got %0h/%0h want %0h/%0h", it, code_word_out, data1_plus_imm8_out, e_cw, e_d1pi); end
            n_cmp++; if (no_operation_out !== nop) begin n_err++; $display("FAIL rand_nop it%0d: got %0b want %0b", it, no_operation_out, nop); end
            n_cmp++; if (return_performed !== (act && op == int'(OP_RETURN))) begin n_err++; $display("FAIL rand_ret it%0d: got %0b want %0b", it, return_performed, act && op == int'(OP_RETURN)); end
        end
    endtask

    task automatic test_call();
        fen = '0; rf[7] = 18'h00100; ip = 18'h00040; ip_plus_one = 18'h00041;
        no_operation = 1'b0; code_word = mk(OP_CALL_IMM14, 0, 2, 0);
        #1;
        n_cmp++; if (reg_read_addr1 !== 3'd7) begin n_err++; $display("FAIL call_sp: got %0d want 7", reg_read_addr1); end
        n_cmp++; if (memory_addr !== 18'h00100 || memory_in !== 18'h00041) begin n_err++; $display("FAIL call_mem: got %0h/%0h want 100/41", memory_addr, memory_in); end
        n_cmp++; if (memory_write_enable !== 1'b1 || call_performed !== 1'b1) begin n_err++; $display("FAIL call_strobe: got we%0b cp%0b want 1/1", memory_write_enable, call_performed); end
        n_cmp++; if (ip_to_call !== 18'h00200) begin n_err++; $display("FAIL call_target: got %0h want 200", ip_to_call); end
        tick();
    endtask

    task automatic test_timed_wait();
        int cnt;
        fen = '0; no_operation = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            int n;
            n = (pass == 0) ? 3 : 2;
            code_word = mk(OP_WAIT, 0, 0, n);
            tick();
            hold_in = (pass == 1);
            cnt = 0;
            while (waiting_global === 1'b1 && cnt < 50) begin
                n_cmp++; if (no_operation_out !== 1'b1) begin n_err++; $display("FAIL twait_nop p%0d c%0d: got %0b want 1", pass, cnt, no_operation_out); end
                cnt++;
                tick();
            end
            hold_in = 1'b0;
            n_cmp++; if (cnt != n) begin n_err++; $display("FAIL twait_len p%0d: got %0d want %0d", pass, cnt, n); end
            n_cmp++; if (no_operation_out !== 1'b1) begin n_err++; $display("FAIL twait_exit_nop p%0d: got %0b want 1", pass, no_operation_out); end
            rf[2] = 18'(18'h01234 + pass);
            code_word = mk(OP_REG_ADD, 2, 0, 0);
            tick();
            n_cmp++; if (no_operation_out !== 1'b0 || alu_data0_out !== 18'(18'h01234 + pass)) begin n_err++; $display("FAIL twait_next p%0d: got %0b/%0h want 0/%0h", pass, no_operation_out, alu_data0_out, 18'h01234 + pass); end
        end
    endtask

    task automatic test_event_wait();
        int stay;
        fen = '0; no_operation = 1'b0;
        code_word = mk(OP_WAIT, 0, 0, 0);
        wake_event = 1'b1;
        tick();
        wake_event = 1'b0;
        n_cmp++; if (waiting_global !== 1'b1) begin n_err++; $display("FAIL ewait_enter: got %0b want 1", waiting_global); end
        stay = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (waiting_global === 1'b1) stay++;
        end
        n_cmp++; if (stay != 20) begin n_err++; $display("FAIL ewait_stay: got %0d want 20", stay); end
        wake_event = 1'b1;
        tick();
        wake_event = 1'b0;
        n_cmp++; if (waiting_global !== 1'b0) begin n_err++; $display("FAIL ewait_wake: got %0b want 0", waiting_global); end
        tick();
        n_cmp++; if (waiting_global !== 1'b1) begin n_err++; $display("FAIL ewait_reenter: got %0b want 1", waiting_global); end
        repeat (5) tick();
        wait_abort = 1'b1;
        tick();
        wait_abort = 1'b0;
        n_cmp++; if (waiting_global !== 1'b0) begin n_err++; $display("FAIL ewait_abort: got %0b want 0", waiting_global); end
        rf[5] = 18'h00055;
        code_word = mk(OP_REG_ADD, 5, 0, 0);
        wait_abort = 1'b1;
        tick();
        wait_abort = 1'b0;
        n_cmp++; if (waiting_global !== 1'b0 || no_operation_out !== 1'b0 || alu_data0_out !== 18'h00055) begin n_err++; $display("FAIL abort_in_run: got w%0b n%0b %0h want 0/0/55", waiting_global, no_operation_out, alu_data0_out); end
    endtask

    task automatic test_hold();
        int we_cnt;
        logic [17:0] add_cw;
        fen = '0; no_operation = 1'b0;
        rf[4] = 18'h00AAA; rf[5] = 18'h00555;
        add_cw = mk(OP_REG_ADD, 4, 5, 0);
        code_word = add_cw;
        tick();
        rf[1] = 18'h03C3C; rf[2] = 18'h00200;
        code_word = mk(OP_STORE, 1, 2, 8'h10);
        hold_in = 1'b1;
        we_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (memory_write_enable === 1'b1) we_cnt++;
            tick();
            n_cmp++; if (alu_data0_out !== 18'h00AAA || code_word_out !== add_cw) begin n_err++; $display("FAIL hold_frozen c%0d: got %0h/%0h want aaa/%0h", i, alu_data0_out, code_word_out, add_cw); end
        end
        hold_in = 1'b0;
        #1;
        if (memory_write_enable === 1'b1) we_cnt++;
        n_cmp++; if (memory_addr !== 18'h00210 || memory_in !== 18'h03C3C) begin n_err++; $display("FAIL hold_store_mem: got %0h/%0h want 210/3c3c", memory_addr, memory_in); end
        tick();
        n_cmp++; if (alu_data0_out !== 18'h03C3C || data1_plus_imm8_out !== 18'h00210) begin n_err++; $display("FAIL hold_release: got %0h/%0h want 3c3c/210", alu_data0_out, data1_plus_imm8_out); end
        no_operation = 1'b1;
        #1;
        if (memory_write_enable === 1'b1) we_cnt++;
        tick();
        n_cmp++; if (we_cnt != 1) begin n_err++; $display("FAIL hold_store_once: got %0d want 1", we_cnt); end
    endtask

    task automatic test_reset_mid_wait();
        fen = '0; no_operation = 1'b0;
        code_word = mk(OP_WAIT, 0, 0, 9);
        tick();
        repeat (4) tick();
        n_cmp++; if (waiting_global !== 1'b1) begin n_err++; $display("FAIL rwait_pre: got %0b want 1", waiting_global); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (waiting_global !== 1'b0 || no_operation_out !== 1'b1 || alu_data0_out !== '0) begin n_err++; $display("FAIL rwait_async: got w%0b n%0b %0h want 0/1/0", waiting_global, no_operation_out, alu_data0_out); end
        rf[6] = 18'h00777;
        code_word = mk(OP_REG_ADD, 6, 0, 0);
        tick();
        reset_n = 1'b1;
        tick();
        n_cmp++; if (waiting_global !== 1'b0 || no_operation_out !== 1'b0 || alu_data0_out !== 18'h00777) begin n_err++; $display("FAIL rwait_after: got w%0b n%0b %0h want 0/0/777", waiting_global, no_operation_out, alu_data0_out); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forwarding();
        test_random_ops();
        test_call();
        test_timed_wait();
        test_event_wait();
        test_hold();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
